// File: rtl/monolith_pkg.sv
`default_nettype none
// ============================================================================
// Module   : monolith_pkg
// Purpose  : Shared types and constants for the monolith streaming IP
//            (permutation size, issue-controller state encoding, err bits).
// Revision : 1.0 - initial release
// ============================================================================
package monolith_pkg;

    // Field elements per permutation carried by the RX/TX FIFOs.
    localparam int PERM_SIZE = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } issue_state_t;

    // Bit positions inside the sticky err vector.
    localparam int ERR_SPURIOUS_OUT = 0;
    localparam int ERR_SPURIOUS_POP = 1;
    localparam int ERR_LATENCY      = 2;

endpackage
`default_nettype wire

// File: rtl/monolith_token_delay.sv
`default_nettype none
// ============================================================================
// Module   : monolith_token_delay
// Purpose  : DEPTH-deep 1-bit shift register with synchronous reset. A token
//            presented on din appears on dout exactly DEPTH cycles later.
// Ports    : clk   - clock
//            reset - synchronous active-high reset (clears all stages)
//            din   - token in
//            dout  - token out (last stage)
// Revision : 1.0 - initial release
// ============================================================================
module monolith_token_delay
    import monolith_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] r_shift;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_shift <= '0;
                end else begin
                    r_shift <= din;
                end
            end
        end else begin : g_chain
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_shift <= '0;
                end else begin
                    r_shift <= {r_shift[DEPTH-2:0], din};
                end
            end
        end
    endgenerate

    assign dout = r_shift[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/monolith_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : monolith_issue_ctrl
// Purpose  : Credit-based scheduler between the RX permutation FIFO, the
//            stall-free monolith_hash pipeline and the TX permutation FIFO.
//            A permutation is issued only when a TX slot is reserved for it,
//            so no hash result can be dropped.
// Ports    : clk, reset       - clock, synchronous active-high reset
//            enable           - 1 = issue permitted, 0 = drain then idle
//            src_empty        - RX FIFO has no complete permutation
//            issue            - RX pop + hash in_valid (same cycle)
//            hash_out_valid   - hash result valid
//            dst_write        - TX FIFO write strobe (passthrough)
//            dst_pop          - one permutation left the TX FIFO
//            credits          - free reserved TX slots
//            inflight         - permutations inside the hash pipeline
//            busy             - controller not idle
//            err              - sticky errors {latency, spurious pop, spurious out}
//            issued_cnt       - permutations issued (wrapping)
//            done_cnt         - results written to TX FIFO (wrapping)
// Revision : 1.0 - initial release
// ============================================================================
module monolith_issue_ctrl
    import monolith_pkg::*;
#(
    parameter int PIPE_LATENCY = 8,
    parameter int FIFO_SIZE    = 4,
    parameter int CNT_W        = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           src_empty,
    output logic                           issue,
    input  logic                           hash_out_valid,
    output logic                           dst_write,
    input  logic                           dst_pop,
    output logic [$clog2(FIFO_SIZE+1)-1:0] credits,
    output logic [$clog2(FIFO_SIZE+1)-1:0] inflight,
    output logic                           busy,
    output logic [2:0]                     err,
    output logic [CNT_W-1:0]               issued_cnt,
    output logic [CNT_W-1:0]               done_cnt
);

    localparam int CW = $clog2(FIFO_SIZE + 1);
    localparam logic [CW-1:0] FULL_CREDITS = CW'(FIFO_SIZE);

    issue_state_t      r_state;
    logic [CW-1:0]     r_credits;
    logic [CW-1:0]     r_inflight;
    logic [CW-1:0]     r_occupancy;
    logic [2:0]        r_err;
    logic [CNT_W-1:0]  r_issued_cnt;
    logic [CNT_W-1:0]  r_done_cnt;

    logic w_issue;
    logic w_spurious_out;
    logic w_spurious_pop;
    logic w_pop_ok;
    logic w_token_tap;

    // Issue depends only on registered state/credits plus src_empty; a credit
    // returned by dst_pop becomes usable one cycle later.
    assign w_issue = (r_state == RUN) && !src_empty && (r_credits != '0);

    // An out_valid paired with a same-cycle issue is balanced, so only an
    // unpaired result on an empty pipeline is spurious.
    assign w_spurious_out = hash_out_valid && (r_inflight == '0) && !w_issue;
    assign w_spurious_pop = dst_pop && (r_occupancy == '0);
    assign w_pop_ok       = dst_pop && !w_spurious_pop;

    monolith_token_delay #(
        .DEPTH (PIPE_LATENCY)
    ) u_token_delay (
        .clk   (clk),
        .reset (reset),
        .din   (w_issue),
        .dout  (w_token_tap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_credits    <= FULL_CREDITS;
            r_inflight   <= '0;
            r_occupancy  <= '0;
            r_err        <= '0;
            r_issued_cnt <= '0;
            r_done_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE:    if (enable) r_state <= RUN;
                RUN:     if (!enable) r_state <= DRAIN;
                DRAIN: begin
                    if (enable) begin
                        r_state <= RUN;
                    end else if (r_inflight == '0) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            r_credits <= r_credits + CW'(w_pop_ok) - CW'(w_issue);

            if (w_spurious_out) begin
                r_inflight <= '0;
            end else begin
                r_inflight <= r_inflight + CW'(w_issue) - CW'(hash_out_valid);
            end

            r_occupancy <= r_occupancy + CW'(hash_out_valid) - CW'(w_pop_ok);

            if (w_spurious_out) r_err[ERR_SPURIOUS_OUT] <= 1'b1;
            if (w_spurious_pop) r_err[ERR_SPURIOUS_POP] <= 1'b1;
            if (w_token_tap != hash_out_valid) r_err[ERR_LATENCY] <= 1'b1;

            if (w_issue)        r_issued_cnt <= r_issued_cnt + CNT_W'(1);
            if (hash_out_valid) r_done_cnt   <= r_done_cnt + CNT_W'(1);
        end
    end

    assign issue      = w_issue;
    assign dst_write  = hash_out_valid;
    assign credits    = r_credits;
    assign inflight   = r_inflight;
    assign busy       = (r_state != IDLE);
    assign err        = r_err;
    assign issued_cnt = r_issued_cnt;
    assign done_cnt   = r_done_cnt;

endmodule
`default_nettype wire

// File: tb/tb_monolith_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_monolith_issue_ctrl
// Purpose  : Directed self-checking bench for monolith_issue_ctrl with
//            PIPE_LATENCY=8, FIFO_SIZE=4. A bench-side 8-stage shift register
//            stands in for the hash pipeline; inj forces extra out_valids.
// Revision : 1.0 - initial release
// ============================================================================
module tb_monolith_issue_ctrl;

    localparam int PL    = 8;
    localparam int FS    = 4;
    localparam int CNT_W = 32;
    localparam int CW    = $clog2(FS + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             src_empty;
    logic             issue;
    logic             hash_out_valid;
    logic             dst_write;
    logic             dst_pop;
    logic [CW-1:0]    credits;
    logic [CW-1:0]    inflight;
    logic             busy;
    logic [2:0]       err;
    logic [CNT_W-1:0] issued_cnt;
    logic [CNT_W-1:0] done_cnt;

    logic             inj;
    logic [PL-1:0]    pipe;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // Hash pipeline model: every issue returns exactly PL cycles later.
    always @(posedge clk) begin
        if (reset) pipe <= '0;
        else       pipe <= {pipe[PL-2:0], issue};
    end
    assign hash_out_valid = pipe[PL-1] | inj;

    monolith_issue_ctrl #(
        .PIPE_LATENCY (PL),
        .FIFO_SIZE    (FS),
        .CNT_W        (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .src_empty      (src_empty),
        .issue          (issue),
        .hash_out_valid (hash_out_valid),
        .dst_write      (dst_write),
        .dst_pop        (dst_pop),
        .credits        (credits),
        .inflight       (inflight),
        .busy           (busy),
        .err            (err),
        .issued_cnt     (issued_cnt),
        .done_cnt       (done_cnt)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    logic [13:0] pat;
    logic        any_issue;
    logic [CW-1:0] cr5;
    logic [CW-1:0] if5;

    initial begin
        reset = 1'b1; enable = 1'b0; src_empty = 1'b1; dst_pop = 1'b0; inj = 1'b0;
        pat = '0; any_issue = 1'b0; cr5 = '0; if5 = '0;

        // ---------------- reset values
        cyc(); cyc(); #1;
        check("rst_credits",  credits, FS);
        check("rst_inflight", inflight, 0);
        check("rst_busy",     busy, 0);
        check("rst_err",      err, 0);
        check("rst_issue",    issue, 0);
        check("rst_cnts",     {issued_cnt, done_cnt}, 0);
        cyc(); reset = 1'b0;

        // ---------------- fill: issues on offsets 1..4, results 9..12
        cyc(); enable = 1'b1; src_empty = 1'b0;
        for (int t = 0; t < 14; t++) begin
            #1;
            pat[t] = issue;
            if (t == 5) begin cr5 = credits; if5 = inflight; end
            cyc();
        end
        check("fill_issue_pattern", pat, 14'b00_0000_0001_1110);
        check("fill_credits_at5",   cr5, 0);
        check("fill_inflight_at5",  if5, 4);
        #1;
        check("fill_credits_end",   credits, 0);
        check("fill_inflight_end",  inflight, 0);
        check("fill_err",           err, 0);
        check("fill_issued",        issued_cnt, 4);
        check("fill_done",          done_cnt, 4);

        // ---------------- single dst_pop from full
        cyc(); dst_pop = 1'b1; #1;
        check("pop_no_bypass_issue", issue, 0);
        cyc(); dst_pop = 1'b0; #1;
        check("pop_credit_back", credits, 1);
        check("pop_reissue",     issue, 1);
        cyc(); #1;
        check("pop_credits_zero", credits, 0);
        check("pop_inflight",     inflight, 1);
        check("pop_issued",       issued_cnt, 5);
        repeat (9) cyc();
        #1;
        check("pop_done",         done_cnt, 5);
        check("pop_inflight_end", inflight, 0);

        // ---------------- drain with three in flight
        cyc(); dst_pop = 1'b1;                  // Q
        cyc(); #1; check("drn_issue_q1", issue, 1);   // Q+1
        cyc();                                  // Q+2
        cyc(); dst_pop = 1'b0; #1;              // Q+3
        check("drn_issue_q3",   issue, 1);
        check("drn_credits_q3", credits, 1);
        cyc(); enable = 1'b0; #1;               // Q+4
        check("drn_inflight3",  inflight, 3);
        check("drn_no_credit",  issue, 0);
        cyc(); dst_pop = 1'b1; #1;              // Q+5, now DRAIN
        check("drn_busy",       busy, 1);
        cyc(); dst_pop = 1'b0; #1;              // Q+6
        check("drn_credit_avail", credits, 1);
        any_issue = issue;
        repeat (5) begin cyc(); #1; any_issue |= issue; end   // Q+11
        check("drn_last_out_write", dst_write, 1);
        check("drn_busy_last_out",  busy, 1);
        cyc(); #1; any_issue |= issue;          // Q+12
        cyc(); #1; any_issue |= issue;          // Q+13
        check("drn_idle",       busy, 0);
        check("drn_no_issue",   any_issue, 0);
        check("drn_issued",     issued_cnt, 8);
        check("drn_done",       done_cnt, 8);
        check("drn_inflight0",  inflight, 0);
        check("drn_err",        err, 0);

        // ---------------- same-cycle issue + out_valid + pop
        cyc(); enable = 1'b1; src_empty = 1'b1; #1;   // R (IDLE)
        check("sim_idle_issue", issue, 0);
        cyc(); src_empty = 1'b0; #1;            // R+1
        check("sim_first_issue", issue, 1);
        cyc(); src_empty = 1'b1;                // R+2
        cyc(); dst_pop = 1'b1;                  // R+3
        cyc(); dst_pop = 1'b0; #1;              // R+4
        check("sim_credits_pre", credits, 1);
        repeat (5) cyc();                       // R+9
        src_empty = 1'b0; dst_pop = 1'b1; #1;
        check("sim_issue",     issue, 1);
        check("sim_dst_write", dst_write, 1);
        check("sim_inflight_pre", inflight, 1);
        cyc(); src_empty = 1'b1; dst_pop = 1'b0; #1;  // R+10
        check("sim_credits",  credits, 1);
        check("sim_inflight", inflight, 1);
        check("sim_issued",   issued_cnt, 10);
        check("sim_done",     done_cnt, 9);
        check("sim_err",      err, 0);
        repeat (8) cyc();                       // R+18
        #1;
        check("sim_inflight_end", inflight, 0);
        check("sim_done_end",     done_cnt, 10);
        check("sim_err_end",      err, 0);

        // ---------------- spurious out_valid on empty pipeline
        cyc(); inj = 1'b1; #1;
        check("spur_dst_write", dst_write, 1);
        check("spur_no_issue",  issue, 0);
        cyc(); inj = 1'b0; #1;
        check("spur_err",       err, 3'b101);
        check("spur_inflight",  inflight, 0);
        check("spur_done",      done_cnt, 11);
        repeat (3) cyc();
        #1;
        check("spur_err_sticky", err, 3'b101);

        // ---------------- reset, then pop with empty TX FIFO
        cyc(); reset = 1'b1; enable = 1'b0;
        cyc(); reset = 1'b0; #1;
        check("rst2_err", err, 0);
        cyc(); dst_pop = 1'b1;
        cyc(); dst_pop = 1'b0; #1;
        check("epop_err",     err, 3'b010);
        check("epop_credits", credits, FS);

        // ---------------- reset mid-RUN with two in flight
        cyc(); reset = 1'b1;
        cyc(); reset = 1'b0;
        cyc(); enable = 1'b1; src_empty = 1'b0; // S
        cyc();                                  // S+1 issue
        cyc();                                  // S+2 issue
        cyc(); src_empty = 1'b1; #1;            // S+3
        check("mid_inflight", inflight, 2);
        check("mid_credits",  credits, 2);
        reset = 1'b1;
        cyc(); reset = 1'b0; enable = 1'b0; #1; // S+4
        check("mid_rst_credits",  credits, FS);
        check("mid_rst_inflight", inflight, 0);
        check("mid_rst_busy",     busy, 0);
        check("mid_rst_err",      err, 0);
        check("mid_rst_cnts",     {issued_cnt, done_cnt}, 0);
        check("mid_rst_outs",     {issue, dst_write}, 0);
        repeat (12) cyc();
        #1;
        check("mid_rst_quiet_err", err, 0);
        check("mid_rst_quiet_done", done_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
